screen_scan: RTL and testbench
==============================

SCREEN_SCAN -- requirements
Module: screen_scan

Interface
REQ-001 Parameter FB_BASE, 12'h100, framebuffer byte address of pixel (0,0).
REQ-002 Parameter ROW_STRIDE, 16, byte distance between consecutive rows.
REQ-003 Parameter ROW_BYTES, 8, bytes per row (64 pixels).
REQ-004 Parameter ROWS, 32, rows per frame.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle request to scan one full frame.
REQ-008 busy  output  1  high from cycle after accepted start until frame_done.
REQ-009 frame_done  output  1  one-cycle pulse after last pixel accepted.
REQ-010 mem_read  output  1  read request to memory.
REQ-011 mem_read_idx  output  12  byte address of request.
REQ-012 mem_read_byte  input  8  read data, valid in mem_read_ack cycle.
REQ-013 mem_read_ack  input  1  read completion strobe.
REQ-014 pix_valid  output  1  pixel stream valid.
REQ-015 pix_ready  input  1  downstream accepts pixel when high with pix_valid.
REQ-016 pix_data  output  1  pixel value (1 = lit).
REQ-017 pix_x  output  6  column of pix_data, 0..63.
REQ-018 pix_y  output  5  row of pix_data, 0..31.

Function
REQ-019 Block SHALL read framebuffer written by gpu and emit every pixel once per frame, row-major, x ascending, y ascending.
REQ-020 Byte address SHALL be FB_BASE + y*ROW_STRIDE + x/8, computed modulo 2^12; bit 7 of each byte SHALL be leftmost pixel.
REQ-021 States SHALL be IDLE, FETCH, SHIFT; IDLE->FETCH on start, FETCH->SHIFT on mem_read_ack, SHIFT->FETCH after 8th pixel handshake of a non-final byte, SHIFT->IDLE after final pixel handshake.
REQ-022 start sampled high in IDLE at edge k SHALL give busy=1, mem_read=1, mem_read_idx=FB_BASE from cycle k+1.
REQ-023 mem_read and mem_read_idx SHALL stay stable until the cycle mem_read_ack=1; mem_read SHALL drop the cycle after ack unless the next request is issued.
REQ-024 mem_read_ack while no request outstanding SHALL be ignored.
REQ-025 Byte captured at ack edge a SHALL produce pix_valid=1 with bit 7 from cycle a+1.
REQ-026 pix_data, pix_x, pix_y SHALL hold stable while pix_valid=1 and pix_ready=0; advance exactly one pixel per cycle with both high.
REQ-027 pix_ready=1 continuously and ack latency L SHALL give exactly 8 pixel handshakes between consecutive byte fetches.
REQ-028 start while busy SHALL be ignored; no queuing.
REQ-029 After pixel (63,31) handshake at edge e, frame_done=1 and busy=0 SHALL appear in cycle e+1 for exactly one cycle; mem_read=0, pix_valid=0.
REQ-030 start in the frame_done cycle SHALL be accepted (state already IDLE).
REQ-031 mem_read_idx SHALL never exceed FB_BASE+(ROWS-1)*ROW_STRIDE+ROW_BYTES-1 (before modulo).

Reset
REQ-032 rst_n low SHALL immediately force IDLE; busy, frame_done, mem_read, pix_valid, pix_data = 0; mem_read_idx, pix_x, pix_y = 0.
REQ-033 Reset mid-frame SHALL abandon the frame; an ack arriving after reset release SHALL be ignored; no frame_done issued.
REQ-034 Reset deassertion SHALL take effect on the next rising edge; start sampled there is accepted.

Configuration
REQ-035 Macro SCREEN_SCAN_PREFETCH_EN defined: one-byte prefetch buffer; next byte's read SHALL issue the cycle after current byte captured, overlapping shifting; with pix_ready=1 and L<=7 pix_valid SHALL stay high continuously across byte boundaries within the frame.
REQ-036 Macro undefined: no prefetch; next read SHALL issue only after the 8th pixel of current byte is accepted; pix_valid drops for at least L+1 cycles per byte.
REQ-037 Pixel order, addresses and frame_done timing SHALL be identical in both builds.

Verification
REQ-038 Mem 0x100=8'hFF, 0x110=8'hC3, rest 0, pix_ready=1, start -> pixels (0..7,0)=1, (0,1)=1, (1,1)=1, (2..5,1)=0, (6,1)=1, (7,1)=1, others 0; 2048 pixels total; one frame_done.
REQ-039 Address trace of REQ-038 -> 256 reads: 0x100..0x107, 0x110..0x117, ..., 0x2F0..0x2F7, in order.
REQ-040 pix_ready toggling 1-0-0-1 pattern, random ack latency 1..5 -> same 2048-pixel sequence, outputs stable during stalls.
REQ-041 start pulsed again at pixel 100 and in frame_done cycle -> first ignored, second starts new frame at (0,0).
REQ-042 rst_n low at pixel 500 with read outstanding, ack after release -> all outputs 0, no pixel, no frame_done; next start yields full correct frame.
REQ-043 PREFETCH build, pix_ready=1, ack latency 2 -> pix_valid high continuously from first pixel to (63,31).

Source files
------------

// File: rtl/screen_scan.sv
// screen_scan: walks a 1-bpp framebuffer row-major and streams every pixel
// with its (x, y) coordinate over a valid/ready handshake.
// Optional feature: define SCREEN_SCAN_PREFETCH_EN to add a one-byte prefetch
// buffer so the next byte is fetched while the current one is being shifted.
module screen_scan #(
    parameter logic [11:0] FB_BASE    = 12'h100,
    parameter int          ROW_STRIDE = 16,
    parameter int          ROW_BYTES  = 8,
    parameter int          ROWS       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        mem_read,
    output logic [11:0] mem_read_idx,
    input  logic [7:0]  mem_read_byte,
    input  logic        mem_read_ack,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [5:0]  pix_x,
    output logic [4:0]  pix_y
);

    localparam logic [5:0] LAST_X  = 6'(ROW_BYTES * 8 - 1);
    localparam logic [4:0] LAST_Y  = 5'(ROWS - 1);
    localparam logic [2:0] LAST_BX = 3'(ROW_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t      state, state_nxt;

    // Byte being shifted out; bit 7 is always the pixel currently presented.
    logic [7:0]  pix_byte;

    // Byte coordinate of the most recently issued read.
    logic [2:0]  rd_bx, rd_bx_nxt;
    logic [4:0]  rd_y, rd_y_nxt;

    logic        hs, ack_ok, byte_end, frame_end;
    logic        issue_first, issue_next, read_clr, load_mem, done_set;

`ifdef SCREEN_SCAN_PREFETCH_EN
    logic [7:0]  pf_byte;
    logic        pf_valid, load_pf, store_pf, rd_more;
`endif

    // Address is taken modulo 2^12; the truncating cast does the wrap.
    function automatic logic [11:0] byte_addr(input logic [4:0] row, input logic [2:0] col);
        return 12'(32'(FB_BASE) + 32'(row) * 32'(ROW_STRIDE) + 32'(col));
    endfunction

    assign busy      = (state != IDLE);
    assign pix_valid = (state == SHIFT);
    assign pix_data  = pix_byte[7];

    assign hs        = pix_valid & pix_ready;
    // An ack with no read in flight (e.g. a stale one after reset) is dropped here.
    assign ack_ok    = mem_read & mem_read_ack;
    assign byte_end  = hs & (pix_x[2:0] == 3'd7);
    assign frame_end = byte_end & (pix_x == LAST_X) & (pix_y == LAST_Y);

    assign rd_bx_nxt = (rd_bx == LAST_BX) ? 3'd0 : rd_bx + 3'd1;
    assign rd_y_nxt  = (rd_bx == LAST_BX) ? rd_y + 5'd1 : rd_y;

`ifdef SCREEN_SCAN_PREFETCH_EN
    assign rd_more   = !((rd_y == LAST_Y) && (rd_bx == LAST_BX));
`endif

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes for the datapath.
    always_comb begin
        state_nxt   = state;
        issue_first = 1'b0;
        issue_next  = 1'b0;
        read_clr    = 1'b0;
        load_mem    = 1'b0;
        done_set    = 1'b0;
`ifdef SCREEN_SCAN_PREFETCH_EN
        load_pf     = 1'b0;
        store_pf    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = FETCH;
                    issue_first = 1'b1;
                end
            end
            FETCH: begin
                if (ack_ok) begin
                    state_nxt = SHIFT;
                    load_mem  = 1'b1;
`ifdef SCREEN_SCAN_PREFETCH_EN
                    // Start fetching the following byte immediately.
                    if (rd_more) issue_next = 1'b1;
                    else         read_clr   = 1'b1;
`else
                    read_clr  = 1'b1;
`endif
                end
            end
            SHIFT: begin
                if (frame_end) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
`ifdef SCREEN_SCAN_PREFETCH_EN
                else if (byte_end) begin
                    if (pf_valid) begin
                        load_pf    = 1'b1;
                        issue_next = rd_more;
                    end else if (ack_ok) begin
                        // Data arriving exactly at the byte boundary bypasses the buffer.
                        load_mem = 1'b1;
                        if (rd_more) issue_next = 1'b1;
                        else         read_clr   = 1'b1;
                    end else begin
                        state_nxt = FETCH;
                    end
                end else if (ack_ok) begin
                    store_pf = 1'b1;
                    read_clr = 1'b1;
                end
`else
                else if (byte_end) begin
                    state_nxt  = FETCH;
                    issue_next = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read request, pixel coordinate, shift register and frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read     <= 1'b0;
            mem_read_idx <= 12'd0;
            rd_bx        <= 3'd0;
            rd_y         <= 5'd0;
            pix_byte     <= 8'd0;
            pix_x        <= 6'd0;
            pix_y        <= 5'd0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= done_set;

            if (issue_first) begin
                rd_bx        <= 3'd0;
                rd_y         <= 5'd0;
                mem_read_idx <= FB_BASE;
                mem_read     <= 1'b1;
            end else if (issue_next) begin
                rd_bx        <= rd_bx_nxt;
                rd_y         <= rd_y_nxt;
                mem_read_idx <= byte_addr(rd_y_nxt, rd_bx_nxt);
                mem_read     <= 1'b1;
            end else if (read_clr) begin
                mem_read     <= 1'b0;
            end

            if (issue_first) begin
                pix_x <= 6'd0;
                pix_y <= 5'd0;
            end else if (hs) begin
                if (pix_x == LAST_X) begin
                    pix_x <= 6'd0;
                    pix_y <= pix_y + 5'd1;
                end else begin
                    pix_x <= pix_x + 6'd1;
                end
            end

            if (load_mem) begin
                pix_byte <= mem_read_byte;
            end
`ifdef SCREEN_SCAN_PREFETCH_EN
            else if (load_pf) begin
                pix_byte <= pf_byte;
            end
`endif
            else if (hs) begin
                pix_byte <= {pix_byte[6:0], 1'b0};
            end
        end
    end

`ifdef SCREEN_SCAN_PREFETCH_EN
    // One-byte prefetch buffer holding the next byte while the current one shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid <= 1'b0;
            pf_byte  <= 8'd0;
        end else if (issue_first) begin
            pf_valid <= 1'b0;
        end else if (store_pf) begin
            pf_byte  <= mem_read_byte;
            pf_valid <= 1'b1;
        end else if (load_pf) begin
            pf_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_screen_scan.sv
// tb_screen_scan: scoreboard bench for screen_scan. Expected addresses and
// pixels are pushed when a frame is started and popped as the DUT produces them.
module tb_screen_scan;

    localparam logic [11:0] TB_BASE   = 12'h100;
    localparam int          TB_STRIDE = 16;
    localparam int          TB_BYTES  = 8;
    localparam int          TB_ROWS   = 32;

    logic        clk, rst_n, start;
    logic        busy, frame_done, mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;
    logic        pix_valid, pix_ready, pix_data;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;

    screen_scan dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .frame_done   (frame_done),
        .mem_read     (mem_read),
        .mem_read_idx (mem_read_idx),
        .mem_read_byte(mem_read_byte),
        .mem_read_ack (mem_read_ack),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_x        (pix_x),
        .pix_y        (pix_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [4096];
    logic [11:0] exp_addr_q[$];
    logic [11:0] exp_pix_q[$];   // {y, x, data}

    int errors = 0;
    int checks = 0;

    // Responder: lat = number of cycles mem_read is seen high, ack cycle included.
    int          lat_min, lat_max, lat_cur, wait_cnt;
    bit          resp_en, inject_ack;
    logic [11:0] req_addr;

    int          ready_mode, ready_phase;
    bit          stall_prev, seen_valid;
    logic [5:0]  sx;
    logic [4:0]  sy;
    logic        sd;
    int          pix_count, read_count, fd_count, lit_count, stall_count, gap_cycles;

    task automatic spec_mem();
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        mem[12'h100] = 8'hFF;
        mem[12'h110] = 8'hC3;
    endtask

    task automatic rand_mem();
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    endtask

    task automatic push_frame();
        logic [11:0] a;
        logic [7:0]  b;
        for (int y = 0; y < TB_ROWS; y++) begin
            for (int c = 0; c < TB_BYTES; c++) begin
                a = TB_BASE + 12'(y * TB_STRIDE + c);
                exp_addr_q.push_back(a);
                b = mem[a];
                for (int k = 0; k < 8; k++)
                    exp_pix_q.push_back({5'(y), 6'(c * 8 + k), b[7 - k]});
            end
        end
    endtask

    // One clock cycle of bench activity, evaluated at the falling edge.
    task automatic step();
        logic [11:0] e;
        bit          hs;
        @(negedge clk);
        if (mem_read_ack) begin
            mem_read_ack = 1'b0;
            wait_cnt     = 0;
        end
        if (inject_ack) begin
            mem_read_ack  = 1'b1;
            mem_read_byte = 8'hFF;
            inject_ack    = 1'b0;
        end else if (resp_en && mem_read) begin
            if (wait_cnt == 0) begin
                req_addr = mem_read_idx;
                lat_cur  = $urandom_range(lat_max, lat_min);
            end else begin
                checks++;
                if (mem_read_idx !== req_addr) begin
                    errors++;
                    $display("FAIL addr_hold: got %h want %h", mem_read_idx, req_addr);
                end
            end
            wait_cnt++;
            if (wait_cnt >= lat_cur) begin
                mem_read_ack  = 1'b1;
                mem_read_byte = mem[mem_read_idx];
                read_count++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_addr: got %h want no read", mem_read_idx);
                end else begin
                    e = exp_addr_q.pop_front();
                    if (mem_read_idx !== e) begin
                        errors++;
                        $display("FAIL read_addr: got %h want %h", mem_read_idx, e);
                    end
                end
            end
        end

        pix_ready = (ready_mode == 0) ? 1'b1 : ((ready_phase % 4 == 0) || (ready_phase % 4 == 3));
        ready_phase++;
        if (stall_prev) begin
            stall_count++;
            checks++;
            if (pix_valid !== 1'b1 || pix_x !== sx || pix_y !== sy || pix_data !== sd) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b x=%0d y=%0d d=%0b want v=1 x=%0d y=%0d d=%0b",
                         pix_valid, pix_x, pix_y, pix_data, sx, sy, sd);
            end
        end
        hs = pix_valid && pix_ready;
        if (hs) begin
            pix_count++;
            if (pix_data === 1'b1) lit_count++;
            checks++;
            if (exp_pix_q.size() == 0) begin
                errors++;
                $display("FAIL pixel: got x=%0d y=%0d want no pixel", pix_x, pix_y);
            end else begin
                e = exp_pix_q.pop_front();
                if ({pix_y, pix_x, pix_data} !== e) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d d=%0b want x=%0d y=%0d d=%0b",
                             pix_x, pix_y, pix_data, e[6:1], e[11:7], e[0]);
                end
            end
        end
        stall_prev = pix_valid && !pix_ready;
        sx = pix_x;
        sy = pix_y;
        sd = pix_data;

        if (pix_valid) seen_valid = 1'b1;
        else if (seen_valid && busy) gap_cycles++;

        if (frame_done) begin
            fd_count++;
            seen_valid = 1'b0;
            checks++;
            if (busy !== 1'b0 || mem_read !== 1'b0 || pix_valid !== 1'b0) begin
                errors++;
                $display("FAIL done_state: got busy=%0b rd=%0b v=%0b want 0 0 0", busy, mem_read, pix_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, frame_done, mem_read, pix_valid, pix_data, mem_read_idx, pix_x, pix_y} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b fd=%0b rd=%0b v=%0b d=%0b idx=%h x=%0d y=%0d want all 0",
                     busy, frame_done, mem_read, pix_valid, pix_data, mem_read_idx, pix_x, pix_y);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_frame();
        int pc0, rc0, fd0, lc0;
        spec_mem();
        lat_min = 2; lat_max = 2; ready_mode = 0;
        pc0 = pix_count; rc0 = read_count; fd0 = fd_count; lc0 = lit_count;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %0b want 0", busy);
        end
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, mem_read, mem_read_idx} !== {1'b1, 1'b1, 12'h100}) begin
            errors++;
            $display("FAIL start_resp: got busy=%0b rd=%0b idx=%h want 1 1 100", busy, mem_read, mem_read_idx);
        end
        for (int i = 0; i < 20 && !mem_read_ack; i++) step();
        step();
        checks++;
        if (pix_valid !== 1'b1 || pix_x !== 6'd0 || pix_y !== 5'd0 || pix_data !== 1'b1) begin
            errors++;
            $display("FAIL first_pixel: got v=%0b x=%0d y=%0d d=%0b want 1 0 0 1", pix_valid, pix_x, pix_y, pix_data);
        end
        for (int i = 0; i < 20000 && fd_count == fd0; i++) step();
        checks++;
        if (fd_count != fd0 + 1) begin
            errors++;
            $display("FAIL basic_done: got %0d frame_done want 1", fd_count - fd0);
        end
        checks++;
        if (pix_count - pc0 != 2048 || read_count - rc0 != 256) begin
            errors++;
            $display("FAIL basic_counts: got pixels=%0d reads=%0d want 2048 256", pix_count - pc0, read_count - rc0);
        end
        checks++;
        if (lit_count - lc0 != 12) begin
            errors++;
            $display("FAIL basic_lit: got %0d want 12", lit_count - lc0);
        end
        checks++;
        if (exp_pix_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL basic_left: got pix=%0d addr=%0d outstanding want 0 0", exp_pix_q.size(), exp_addr_q.size());
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got fd=%0b busy=%0b want 0 0", frame_done, busy);
        end
        repeat (10) step();
        checks++;
        if (fd_count != fd0 + 1 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL after_done: got frames=%0d rd=%0b want 1 0", fd_count - fd0, mem_read);
        end
    endtask

    task automatic test_stall();
        int pc0, fd0, st0;
        spec_mem();
        lat_min = 2; lat_max = 6; ready_mode = 1;
        pc0 = pix_count; fd0 = fd_count; st0 = stall_count;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30000 && fd_count == fd0; i++) step();
        checks++;
        if (fd_count != fd0 + 1 || pix_count - pc0 != 2048) begin
            errors++;
            $display("FAIL stall_frame: got frames=%0d pixels=%0d want 1 2048", fd_count - fd0, pix_count - pc0);
        end
        checks++;
        if (stall_count == st0 || exp_pix_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL stall_cover: got stalls=%0d left=%0d want >0 0", stall_count - st0, exp_pix_q.size());
        end
        ready_mode = 0;
        step();
    endtask

    task automatic test_valid_gaps();
        int fd0;
        spec_mem();
        lat_min = 3; lat_max = 3; ready_mode = 0;
        fd0 = fd_count; gap_cycles = 0; seen_valid = 1'b0;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20000 && fd_count == fd0; i++) step();
        checks++;
        if (fd_count != fd0 + 1 || exp_pix_q.size() != 0) begin
            errors++;
            $display("FAIL gap_frame: got frames=%0d left=%0d want 1 0", fd_count - fd0, exp_pix_q.size());
        end
`ifdef SCREEN_SCAN_PREFETCH_EN
        checks++;
        if (gap_cycles != 0) begin
            errors++;
            $display("FAIL valid_continuous: got %0d gap cycles want 0", gap_cycles);
        end
`else
        checks++;
        if (gap_cycles < 255 * 3) begin
            errors++;
            $display("FAIL valid_gaps: got %0d gap cycles want >= %0d", gap_cycles, 255 * 3);
        end
`endif
        step();
    endtask

    task automatic test_start_ignored();
        int pc0, fd0;
        rand_mem();
        lat_min = 2; lat_max = 2; ready_mode = 0;
        pc0 = pix_count; fd0 = fd_count;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5000 && pix_count - pc0 < 100; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start: got busy=%0b want 1", busy);
        end
        for (int i = 0; i < 20000 && fd_count == fd0; i++) step();
        checks++;
        if (fd_count != fd0 + 1 || exp_pix_q.size() != 0 || pix_count - pc0 != 2048) begin
            errors++;
            $display("FAIL ignored_frame: got frames=%0d pixels=%0d want 1 2048", fd_count - fd0, pix_count - pc0);
        end
        // Still in the frame_done cycle: this start must be accepted.
        rand_mem();
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, mem_read, mem_read_idx} !== {1'b1, 1'b1, 12'h100}) begin
            errors++;
            $display("FAIL done_restart: got busy=%0b rd=%0b idx=%h want 1 1 100", busy, mem_read, mem_read_idx);
        end
        for (int i = 0; i < 20000 && fd_count == fd0 + 1; i++) step();
        checks++;
        if (fd_count != fd0 + 2 || exp_pix_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL second_frame: got frames=%0d left=%0d want 2 0", fd_count - fd0, exp_pix_q.size());
        end
        step();
    endtask

    task automatic test_reset_midframe();
        int  pc0, fd0;
        bit  hit;
        rand_mem();
        lat_min = 5; lat_max = 5; ready_mode = 0;
        pc0 = pix_count;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            step();
            hit = (pix_count - pc0 >= 500) && mem_read && !mem_read_ack;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reach: got %0d pixels want >= 500 with read pending", pix_count - pc0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, mem_read, pix_valid, pix_data, mem_read_idx, pix_x, pix_y} !== 30'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%0b rd=%0b v=%0b d=%0b idx=%h x=%0d y=%0d want all 0",
                     busy, mem_read, pix_valid, pix_data, mem_read_idx, pix_x, pix_y);
        end
        exp_pix_q.delete();
        exp_addr_q.delete();
        stall_prev = 1'b0; seen_valid = 1'b0; wait_cnt = 0; resp_en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        pc0 = pix_count; fd0 = fd_count;
        inject_ack = 1'b1;
        repeat (20) step();
        checks++;
        if (pix_count != pc0 || fd_count != fd0 || {busy, mem_read, pix_valid, frame_done} !== 4'd0) begin
            errors++;
            $display("FAIL stale_ack: got pixels=%0d frames=%0d busy=%0b rd=%0b v=%0b want 0 0 0 0 0",
                     pix_count - pc0, fd_count - fd0, busy, mem_read, pix_valid);
        end
        resp_en = 1'b1;
        lat_min = 2; lat_max = 4;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20000 && fd_count == fd0; i++) step();
        checks++;
        if (fd_count != fd0 + 1 || pix_count - pc0 != 2048 || exp_pix_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_frame: got frames=%0d pixels=%0d want 1 2048", fd_count - fd0, pix_count - pc0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
        mem_read_ack = 1'b0; mem_read_byte = 8'h00;
        resp_en = 1'b1; inject_ack = 1'b0; wait_cnt = 0; lat_cur = 1;
        lat_min = 2; lat_max = 2; ready_mode = 0; ready_phase = 0;
        stall_prev = 1'b0; seen_valid = 1'b0; req_addr = 12'd0;
        sx = 6'd0; sy = 5'd0; sd = 1'b0;
        pix_count = 0; read_count = 0; fd_count = 0; lit_count = 0; stall_count = 0; gap_cycles = 0;
        spec_mem();

        test_reset();
        test_basic_frame();
        test_stall();
        test_valid_gaps();
        test_start_ignored();
        test_reset_midframe();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
